// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control sequencer (optional perf counters: MIPS_CTRL_PERF_CNT_EN)
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       state_o,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_REXE = 4'd7,
                           S_RWB = 4'd8, S_BEQ = 4'd9, S_JMP = 4'd10, S_ADDIEX = 4'd11,
                           S_ADDIWB = 4'd12, S_TRAP = 4'd15;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       trap;
        logic [1:0] trap_code;
    } ctl_t;

    logic [3:0] state, next_state;
    logic [7:0] wait_cnt;
    logic [1:0] trap_cause;
    logic       mem_state, timeout, fetch_ack;
    ctl_t       ctl_d, ctl_q;

    // zero is gated with pc_write_cond inside the datapath, not here
    logic unused_zero;
    assign unused_zero = zero;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout   = mem_state && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign fetch_ack = (state == S_FETCH) && mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state || mem_ready || !mem_state)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        next_state = state;
        trap_cause = 2'b00;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         next_state = S_REXE;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_J:         next_state = S_JMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default: begin
                        next_state = S_TRAP;
                        trap_cause = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      next_state = S_MEMRD;
                else if (opcode == OP_SW) next_state = S_MEMWR;
                else begin
                    next_state = S_TRAP;
                    trap_cause = 2'b01;
                end
            end
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_REXE:   next_state = S_RWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQ, S_JMP, S_ADDIWB: next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default: begin
                next_state = S_TRAP;
                trap_cause = 2'b01;
            end
        endcase
        if (timeout) begin
            next_state = S_TRAP;
            trap_cause = 2'b10;
        end
    end

    // Level controls are decoded from the next state so they are flop outputs aligned with state
    always_comb begin
        ctl_d = '0;
        case (next_state)
            S_FETCH: begin
                ctl_d.mem_read  = 1'b1;
                ctl_d.alu_src_b = 2'b01;
            end
            S_DECODE: ctl_d.alu_src_b = 2'b11;
            S_MEMADR: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctl_d.mem_read = 1'b1;
                ctl_d.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctl_d.mem_to_reg = 1'b1;
                ctl_d.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctl_d.mem_write = 1'b1;
                ctl_d.iord      = 1'b1;
            end
            S_REXE: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_op    = 2'b10;
            end
            S_RWB: begin
                ctl_d.reg_dst   = 1'b1;
                ctl_d.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctl_d.alu_src_a     = 1'b1;
                ctl_d.alu_op        = 2'b01;
                ctl_d.pc_write_cond = 1'b1;
                ctl_d.pc_source     = 2'b01;
            end
            S_JMP: begin
                ctl_d.pc_write  = 1'b1;
                ctl_d.pc_source = 2'b10;
            end
            S_ADDIEX: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = 2'b10;
            end
            S_ADDIWB: ctl_d.reg_write = 1'b1;
            S_TRAP: begin
                ctl_d.trap      = 1'b1;
                ctl_d.trap_code = (state == S_TRAP) ? ctl_q.trap_code : trap_cause;
            end
            default: ctl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ctl_q <= '0;
        else       ctl_q <= ctl_d;
    end

    assign mem_read      = ctl_q.mem_read;
    assign mem_write     = ctl_q.mem_write;
    assign iord          = ctl_q.iord;
    assign ir_write      = fetch_ack;
    assign pc_write      = ctl_q.pc_write | fetch_ack;
    assign pc_write_cond = ctl_q.pc_write_cond;
    assign pc_source     = ctl_q.pc_source;
    assign alu_src_a     = ctl_q.alu_src_a;
    assign alu_src_b     = ctl_q.alu_src_b;
    assign alu_op        = ctl_q.alu_op;
    assign reg_dst       = ctl_q.reg_dst;
    assign mem_to_reg    = ctl_q.mem_to_reg;
    assign reg_write     = ctl_q.reg_write;
    assign trap          = ctl_q.trap;
    assign trap_code     = ctl_q.trap_code;
    assign state_o       = state;

`ifdef MIPS_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_TRAP && cycle_cnt != {CNT_W{1'b1}})
                cycle_cnt <= cycle_cnt + 1'b1;
            if (next_state == S_FETCH && state != S_IDLE && state != S_FETCH &&
                instr_cnt != {CNT_W{1'b1}})
                instr_cnt <= instr_cnt + 1'b1;
        end
    end
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source, alu_src_b, alu_op, trap_code;
    logic        alu_src_a, reg_dst, mem_to_reg, reg_write, trap;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt, instr_cnt;
    logic [18:0] dut_ctl;

    int tests = 0;
    int fails = 0;
    int m_cycles = 0;
    int m_instrs = 0;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state_o(state_o), .trap(trap),
        .trap_code(trap_code), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign dut_ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                      alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, trap, trap_code};

    // Control table: what every strobe should read while sitting in a given state
    function automatic logic [18:0] exp_ctl(int st, logic rdy, logic [1:0] tc);
        logic mr, mw, io, irw, pcw, pcc, asa, rd, m2r, rw, tr;
        logic [1:0] pcs, asb, aop, tco;
        {mr, mw, io, irw, pcw, pcc, asa, rd, m2r, rw, tr} = '0;
        {pcs, asb, aop, tco} = '0;
        case (st)
            1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; io = 1; end
            5:  begin m2r = 1; rw = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rd = 1; rw = 1; end
            9:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin asa = 1; asb = 2'b10; end
            12: rw = 1;
            15: begin tr = 1; tco = tc; end
            default: ;
        endcase
        return {mr, mw, io, irw, pcw, pcc, pcs, asa, asb, aop, rd, m2r, rw, tr, tco};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_cycles = 0;
        m_instrs = 0;
    endtask

    // Walks one instruction from FETCH; each memory state stalls for the given count before ready
    task automatic run_instr(input logic [5:0] op, input int st_f, input int st_rd, input int st_wr,
                             input string tag);
        int   path[$];
        int   st, n;
        logic rdy;
        path.push_back(1);
        path.push_back(2);
        case (op)
            6'b000000: begin path.push_back(7); path.push_back(8); end
            6'b100011: begin path.push_back(3); path.push_back(4); path.push_back(5); end
            6'b101011: begin path.push_back(3); path.push_back(6); end
            6'b000100: path.push_back(9);
            6'b000010: path.push_back(10);
            default:   begin path.push_back(11); path.push_back(12); end
        endcase
        opcode = op;
        foreach (path[i]) begin
            st = path[i];
            n = (st == 1) ? st_f : (st == 4) ? st_rd : (st == 6) ? st_wr : 0;
            for (int k = 0; k <= n; k++) begin
                if (st == 1 || st == 4 || st == 6) rdy = (k == n);
                else rdy = 1'($urandom_range(0, 1));
                @(negedge clk);
                mem_ready = rdy;
                #1;
                tests++;
                if (state_o !== 4'(st) || dut_ctl !== exp_ctl(st, rdy, 2'b00)) begin
                    fails++;
                    $display("FAIL %s op=%b step=%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                             tag, op, i, state_o, dut_ctl, st, exp_ctl(st, rdy, 2'b00));
                end
                m_cycles++;
            end
        end
        m_instrs++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (state_o !== 4'd0 || dut_ctl !== 19'd0 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: state=%0d ctl=%b cyc=%0d ins=%0d, expected all 0",
                     state_o, dut_ctl, cycle_cnt, instr_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (state_o !== 4'd0 || dut_ctl !== 19'd0) begin
            fails++;
            $display("FAIL reset_idle: state=%0d ctl=%b, expected 0 and 0", state_o, dut_ctl);
        end
        m_cycles = 0;
        m_instrs = 0;
        run_instr(6'b000000, 0, 0, 0, "first_after_reset");
    endtask

    task automatic test_rtype();
        do_reset();
        run_instr(6'b000000, 0, 0, 0, "rtype_a");
        run_instr(6'b000000, 2, 0, 0, "rtype_fetch_stall");
    endtask

    task automatic test_lw_stall();
        run_instr(6'b100011, 0, 3, 0, "lw_stall3");
        run_instr(6'b101011, 1, 0, 2, "sw_stall2");
    endtask

    task automatic test_beq_j();
        run_instr(6'b000100, 0, 0, 0, "beq");
        run_instr(6'b000010, 0, 0, 0, "jump");
        run_instr(6'b001000, 0, 0, 0, "addi");
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        do_reset();
        for (int i = 0; i < 40; i++)
            run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 4), $urandom_range(0, 6),
                      $urandom_range(0, 6), "random");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests++;
`ifdef MIPS_CTRL_PERF_CNT_EN
        if (cycle_cnt !== 32'(m_cycles) || instr_cnt !== 32'(m_instrs)) begin
            fails++;
            $display("FAIL random_counters: cyc=%0d ins=%0d, expected cyc=%0d ins=%0d",
                     cycle_cnt, instr_cnt, m_cycles, m_instrs);
        end
`else
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            fails++;
            $display("FAIL random_counters: cyc=%0d ins=%0d, expected 0 0", cycle_cnt, instr_cnt);
        end
`endif
    endtask

    task automatic test_illegal();
        logic       rdy;
        logic [5:0] ops [2];
        ops = '{6'b111111, 6'b010101};
        foreach (ops[j]) begin
            do_reset();
            opcode = ops[j];
            @(negedge clk);
            mem_ready = 1'b1;
            @(negedge clk);
            #1;
            tests++;
            if (state_o !== 4'd2) begin
                fails++;
                $display("FAIL illegal_decode: state=%0d, expected 2", state_o);
            end
            for (int k = 0; k < 6; k++) begin
                rdy = 1'($urandom_range(0, 1));
                @(negedge clk);
                mem_ready = rdy;
                opcode = 6'($urandom);
                #1;
                tests++;
                if (state_o !== 4'd15 || dut_ctl !== exp_ctl(15, rdy, 2'b01)) begin
                    fails++;
                    $display("FAIL illegal_trap: state=%0d ctl=%b, expected state=15 ctl=%b",
                             state_o, dut_ctl, exp_ctl(15, rdy, 2'b01));
                end
            end
        end
        do_reset();
        #1;
        tests++;
        if (trap !== 1'b0 || trap_code !== 2'b00) begin
            fails++;
            $display("FAIL trap_clear: trap=%b code=%b, expected 0 00", trap, trap_code);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            tests++;
            if (state_o !== 4'd1) begin
                fails++;
                $display("FAIL timeout_wait: cycle=%0d state=%0d, expected 1", k, state_o);
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        tests++;
        if (state_o !== 4'd15 || dut_ctl !== exp_ctl(15, 1'b1, 2'b10)) begin
            fails++;
            $display("FAIL timeout_trap: state=%0d ctl=%b, expected state=15 ctl=%b",
                     state_o, dut_ctl, exp_ctl(15, 1'b1, 2'b10));
        end
        do_reset();
        run_instr(6'b100011, 14, 14, 0, "lw_stall14");
        run_instr(6'b101011, 0, 0, 3, "sw_before_abort");
        opcode = 6'b101011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = (k == 0);
        end
        #1;
        tests++;
        if (state_o !== 4'd6 || mem_write !== 1'b1) begin
            fails++;
            $display("FAIL memwr_entry: state=%0d mem_write=%b, expected 6 1", state_o, mem_write);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (state_o !== 4'd0 || mem_write !== 1'b0 || dut_ctl !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid_memwr: state=%0d mem_write=%b ctl=%b, expected 0 0 0",
                     state_o, mem_write, dut_ctl);
        end
        @(negedge clk);
        reset = 1'b0;
        m_cycles = 0;
        m_instrs = 0;
    endtask

    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 10; i++) run_instr(6'b000000, 0, 0, 0, "perf_rtype");
        @(negedge clk);
        #1;
        tests++;
`ifdef MIPS_CTRL_PERF_CNT_EN
        if (instr_cnt !== 32'd10 || cycle_cnt !== 32'd40) begin
            fails++;
            $display("FAIL perf_10_rtype: ins=%0d cyc=%0d, expected 10 40", instr_cnt, cycle_cnt);
        end
`else
        if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
            fails++;
            $display("FAIL perf_off: ins=%0d cyc=%0d, expected 0 0", instr_cnt, cycle_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq_j();
        test_random();
        test_illegal();
        test_timeout();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
